// File: rtl/mem_req_master.sv
// Request master for memory_interface: buffers producer commands in a FIFO and
// issues them one at a time, returning read data and pulsing a write-done strobe.
module mem_req_master #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic                       cmd_rnw_i,
    input  logic [ADDR_W-1:0]          cmd_addr_i,
    input  logic [DATA_W-1:0]          cmd_wdata_i,
    output logic                       req_o,
    output logic                       req_rnw_o,
    output logic [ADDR_W-1:0]          req_addr_o,
    output logic [DATA_W-1:0]          req_wdata_o,
    input  logic                       req_ready_i,
    input  logic [DATA_W-1:0]          req_rdata_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       wr_done_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
    output logic                       busy_o,
    output logic [1:0]                 state_dbg_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

    state_t state, next_state;

    logic              rnw_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [DATA_W-1:0] wdata_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    // Every channel transfers on a rising edge where its valid (cmd_valid_i,
    // req_o, rsp_valid_o) and ready are both high; a raised valid holds its
    // payload stable until that transfer edge.
    assign cmd_ready_o  = (count != CNT_W'(DEPTH));
    assign push         = cmd_valid_i && cmd_ready_o;
    assign pop          = (state == IDLE) && (count != '0);
    assign fifo_count_o = count;

    always_ff @(posedge clk) begin
        if (push) begin
            rnw_mem[wr_ptr]   <= cmd_rnw_i;
            addr_mem[wr_ptr]  <= cmd_addr_i;
            wdata_mem[wr_ptr] <= cmd_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = REQ;
            REQ:     if (req_ready_i) next_state = req_rnw_o ? RSP : IDLE;
            RSP:     if (rsp_ready_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request and response valids follow the state so reset drops them at once.
    assign req_o       = (state == REQ);
    assign rsp_valid_o = (state == RSP);
    assign busy_o      = (state != IDLE);
    assign state_dbg_o = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_rnw_o   <= 1'b0;
            req_addr_o  <= '0;
            req_wdata_o <= '0;
            rsp_rdata_o <= '0;
            wr_done_o   <= 1'b0;
        end else begin
            wr_done_o <= (state == REQ) && req_ready_i && !req_rnw_o;
            if (pop) begin
                req_rnw_o   <= rnw_mem[rd_ptr];
                req_addr_o  <= addr_mem[rd_ptr];
                req_wdata_o <= wdata_mem[rd_ptr];
            end
            if ((state == REQ) && req_ready_i && req_rnw_o) rsp_rdata_o <= req_rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: directed scenarios plus random traffic, checked each
// cycle against a transaction-level model built on a command queue.
module tb_mem_req_master;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int CMD_W  = 1 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rnw = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              req;
    logic              req_rnw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready = 1'b0;
    logic [DATA_W-1:0] req_rdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              wr_done;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    mem_req_master #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_rnw_i(cmd_rnw),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .req_o(req), .req_rnw_o(req_rnw), .req_addr_o(req_addr), .req_wdata_o(req_wdata),
        .req_ready_i(req_ready), .req_rdata_i(req_rdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .wr_done_o(wr_done), .fifo_count_o(fifo_count), .busy_o(busy),
        .state_dbg_o(state_dbg)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: buffered commands, the command in flight, and the held response.
    logic [CMD_W-1:0]  exp_q[$];
    logic [CMD_W-1:0]  m_cur;
    logic [DATA_W-1:0] m_rsp;
    bit                m_in_req, m_in_rsp, m_wr_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cur     = '0;
        m_rsp     = '0;
        m_in_req  = 0;
        m_in_rsp  = 0;
        m_wr_done = 0;
    endtask

    task automatic model_edge();
        bit can_push;
        can_push  = cmd_valid && (exp_q.size() < DEPTH);
        m_wr_done = 0;
        if (m_in_req) begin
            if (req_ready) begin
                m_in_req = 0;
                if (m_cur[CMD_W-1]) begin
                    m_in_rsp = 1;
                    m_rsp    = req_rdata;
                end else begin
                    m_wr_done = 1;
                end
            end
        end else if (m_in_rsp) begin
            if (rsp_ready) m_in_rsp = 0;
        end else if (exp_q.size() > 0) begin
            m_cur    = exp_q.pop_front();
            m_in_req = 1;
        end
        if (can_push) exp_q.push_back({cmd_rnw, cmd_addr, cmd_wdata});
    endtask

    task automatic check_outputs();
        check_eq("req_o", 64'(req), 64'(m_in_req));
        check_eq("req_rnw", 64'(req_rnw), 64'(m_cur[CMD_W-1]));
        check_eq("req_addr", 64'(req_addr), 64'(m_cur[CMD_W-2 -: ADDR_W]));
        check_eq("req_wdata", 64'(req_wdata), 64'(m_cur[DATA_W-1:0]));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(m_in_rsp));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp));
        check_eq("wr_done", 64'(wr_done), 64'(m_wr_done));
        check_eq("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
        check_eq("cmd_ready", 64'(cmd_ready), 64'(exp_q.size() != DEPTH));
        check_eq("busy", 64'(busy), 64'(m_in_req || m_in_rsp));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic push_cmd(input logic rnw, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        req_ready = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 80 && (exp_q.size() != 0 || m_in_req || m_in_rsp); i++) begin
            req_rdata = $urandom;
            step();
        end
        check_eq("drain_busy", 64'(busy), 64'd0);
        check_eq("drain_count", 64'(fifo_count), 64'd0);
        req_ready = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_outputs();

        // Reset asserted while a request is outstanding.
        push_cmd(1'b0, 4'h3, 32'h0000aaaa);
        step();
        check_eq("t1_req_hi", 64'(req), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t1_rst_req", 64'(req), 64'd0);
        check_eq("t1_rst_rsp", 64'(rsp_valid), 64'd0);
        check_eq("t1_rst_done", 64'(wr_done), 64'd0);
        check_eq("t1_rst_cnt", 64'(fifo_count), 64'd0);
        check_eq("t1_rst_busy", 64'(busy), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("t1_rel_ready", 64'(cmd_ready), 64'd1);

        // Single write with two stall cycles.
        push_cmd(1'b0, 4'hf, 32'hdeadcafe);
        step();
        step();
        step();
        check_eq("t2_hold_addr", 64'(req_addr), 64'hf);
        check_eq("t2_hold_wdata", 64'(req_wdata), 64'hdeadcafe);
        req_ready = 1'b1;
        step();
        check_eq("t2_done", 64'(wr_done), 64'd1);
        req_ready = 1'b0;
        step();
        check_eq("t2_done_low", 64'(wr_done), 64'd0);

        // Single read with a held response.
        rsp_ready = 1'b0;
        push_cmd(1'b1, 4'hf, 32'h0);
        step();
        req_ready = 1'b1;
        req_rdata = 32'hdeadcafe;
        step();
        check_eq("t3_rdata", 64'(rsp_rdata), 64'hdeadcafe);
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_rdata = $urandom;
            step();
        end
        check_eq("t3_held", 64'(rsp_rdata), 64'hdeadcafe);
        check_eq("t3_no_req", 64'(req), 64'd0);
        rsp_ready = 1'b1;
        step();
        check_eq("t3_idle", 64'(busy), 64'd0);

        // Fill the FIFO behind a stalled request; the sixth command is refused.
        req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_rnw   = 1'(i % 2);
            cmd_addr  = ADDR_W'(i + 1);
            cmd_wdata = $urandom;
            step();
        end
        cmd_valid = 1'b0;
        check_eq("t4_full_cnt", 64'(fifo_count), 64'd4);
        check_eq("t4_full_rdy", 64'(cmd_ready), 64'd0);
        drain();

        // Write/read rounds with random stalls; memory always returns deadcafe.
        req_rdata = 32'hdeadcafe;
        for (int r = 0; r < 3; r++) begin
            push_cmd(1'b0, 4'hf, 32'hdeadcafe);
            push_cmd(1'b1, 4'hf, 32'h0);
        end
        for (int i = 0; i < 60; i++) begin
            req_ready = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();

        // Simultaneous push and pop at count 2.
        req_ready = 1'b0;
        push_cmd(1'b0, 4'h1, 32'h11111111);
        push_cmd(1'b0, 4'h2, 32'h22222222);
        push_cmd(1'b0, 4'h3, 32'h33333333);
        check_eq("t6_cnt_pre", 64'(fifo_count), 64'd2);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        push_cmd(1'b1, 4'h4, 32'h44444444);
        check_eq("t6_cnt_same", 64'(fifo_count), 64'd2);
        check_eq("t6_popped", 64'(req_addr), 64'h2);
        drain();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_rnw   = 1'($urandom_range(0, 1));
            cmd_addr  = ADDR_W'($urandom);
            cmd_wdata = $urandom;
            req_ready = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            req_rdata = $urandom;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_req_master.md
Name: mem_req_master

Overview:
Upstream request master for memory_interface. Accepts read/write commands from a producer over a valid/ready channel and buffers them in a small FIFO. Issues them one at a time on the req_*/req_ready handshake of memory_interface. Returns read data on a valid/ready response channel and pulses a done strobe for writes.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
ADDR_W, 4, address width; matches memory_interface req_addr_i
DATA_W, 32, data width; matches memory_interface req_wdata_i/req_rdata_o

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid_i  in  1  producer command valid
cmd_ready_o  out  1  FIFO can accept a command
cmd_rnw_i  in  1  1=read, 0=write
cmd_addr_i  in  ADDR_W  command address
cmd_wdata_i  in  DATA_W  write data (ignored for reads)
req_o  out  1  drives memory_interface req_i
req_rnw_o  out  1  drives req_rnw_i
req_addr_o  out  ADDR_W  drives req_addr_i
req_wdata_o  out  DATA_W  drives req_wdata_i
req_ready_i  in  1  from memory_interface req_ready_o
req_rdata_i  in  DATA_W  from memory_interface req_rdata_o
rsp_valid_o  out  1  read data valid
rsp_ready_i  in  1  consumer accepts read data
rsp_rdata_o  out  DATA_W  read data
wr_done_o  out  1  one-cycle pulse per completed write
fifo_count_o  out  $clog2(DEPTH+1)  entries currently buffered
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers 0, FSM=IDLE. All outputs 0 except cmd_ready_o=1. Any in-flight request or response is discarded; req_o drops immediately.
- FIFO:
  - push on rising edge when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (count != DEPTH), combinational from count only. When full, no push occurs even if a pop happens on the same edge.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count>0 at the edge, pop head, load req_rnw_o/req_addr_o/req_wdata_o, set req_o=1, go REQ. If count=0, stay.
  - REQ: req_* held stable while req_o=1. At an edge with req_ready_i=1:
    - req_o<=0.
    - Write: wr_done_o<=1 for exactly one cycle, go IDLE.
    - Read: rsp_rdata_o<=req_rdata_i, rsp_valid_o<=1, go RSP.
  - RSP: rsp_valid_o and rsp_rdata_o held until an edge with rsp_ready_i=1, then rsp_valid_o<=0, go IDLE. No new request is issued while in RSP.
- Latency:
  - Command accepted at edge k into an empty FIFO → req_o high after edge k+1.
  - Handshake at edge m → wr_done_o / rsp_valid_o high after edge m.
  - Minimum one IDLE cycle between consecutive requests (back-to-back issue not supported).
- req_ready_i is ignored outside REQ. req_rdata_i is sampled only on the REQ handshake edge.
- busy_o = (state != IDLE). req_addr_o and req_wdata_o retain their last values when req_o=0.

Test Plan:
1. Reset: assert reset=0 mid-REQ with req_o=1 → req_o, rsp_valid_o, wr_done_o, fifo_count_o, busy_o all 0 at once; cmd_ready_o=1 after release.
2. Single write: push rnw=0, addr=4'hf, wdata=32'hdeadcafe; stall req_ready_i 2 cycles → req_o held with addr=f, wdata=deadcafe stable; one wr_done_o pulse after the handshake edge; req_o=0.
3. Single read: push rnw=1, addr=4'hf; memory returns 32'hdeadcafe with ready → rsp_valid_o=1, rsp_rdata_o=deadcafe. Hold rsp_ready_i=0 for 3 cycles → value held, no new req_o; release → IDLE.
4. FIFO full: push 5 commands with req_ready_i=0 → first popped into REQ, next 4 fill the FIFO, fifo_count_o=4, cmd_ready_o=0. 6th cmd_valid_i is not accepted. Drive req_ready_i → commands issued in order; count decrements per pop.
5. Wrap and order: 3 rounds of write deadcafe/read addr f, interleaved with random rsp_ready_i stalls → every read returns deadcafe. Pointers wrap past DEPTH with no loss or duplication.
6. Simultaneous push/pop at count=2 → count stays 2; pushed entry lands at the tail.
